// File: rtl/overture_fetch_if.sv
// Fetch-stage bundle: ROM read port, downstream instruction slot with stall, branch and halt controls.
// master = fetch unit, slave = ROM plus decoder side.
interface overture_fetch_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_rdata;
    logic              stall;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic              halt_req;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic [ADDR_W-1:0] instr_pc;
    logic              halted;

    modport master (
        output mem_addr, mem_rd, instr, instr_valid, instr_pc, halted,
        input  mem_rdata, stall, branch_taken, branch_target, halt_req
    );

    modport slave (
        input  mem_addr, mem_rd, instr, instr_valid, instr_pc, halted,
        output mem_rdata, stall, branch_taken, branch_target, halt_req
    );
endinterface

// File: rtl/overture_fetch.sv
// Instruction fetch: PC, 1-cycle ROM reads, one instr/cycle; first instr 2 cycles after reset, branch bubble 2.
// Stall holds the slot; one outstanding read plus a 1-entry skid mean returning data is never dropped.
module overture_fetch #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    overture_fetch_if.master    bus
);
    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t            state_q;
    logic              halted_q;

    logic [ADDR_W-1:0] pc_q,        pc_d;
    logic              pend_vld_q,  pend_vld_d;
    logic [ADDR_W-1:0] pend_pc_q,   pend_pc_d;
    logic              skid_vld_q,  skid_vld_d;
    logic [DATA_W-1:0] skid_dat_q,  skid_dat_d;
    logic [ADDR_W-1:0] skid_pc_q,   skid_pc_d;
    logic              instr_vld_q, instr_vld_d;
    logic [DATA_W-1:0] instr_dat_q, instr_dat_d;
    logic [ADDR_W-1:0] instr_pc_q,  instr_pc_d;

    logic branch_acc;
    logic advance;
    logic issue;
    logic drained;

    assign branch_acc = bus.branch_taken && instr_vld_q && !bus.stall;
    assign advance    = !instr_vld_q || !bus.stall;

    // Under stall, stop issuing once anything is already in flight or parked,
    // so the skid entry is always free for the one read that can still land.
    assign issue = (state_q == S_RUN) && !rst && !bus.halt_req && !branch_acc
                && !(bus.stall && (pend_vld_q || skid_vld_q));

    assign drained = !pend_vld_q && !skid_vld_q && advance;

    always_comb begin
        pc_d        = pc_q;
        pend_vld_d  = issue;
        pend_pc_d   = pend_pc_q;
        skid_vld_d  = skid_vld_q;
        skid_dat_d  = skid_dat_q;
        skid_pc_d   = skid_pc_q;
        instr_vld_d = instr_vld_q;
        instr_dat_d = instr_dat_q;
        instr_pc_d  = instr_pc_q;

        if (issue) begin
            pc_d      = pc_q + 1'b1;
            pend_pc_d = pc_q;
        end

        if (branch_acc) begin
            pc_d        = bus.branch_target;
            pend_vld_d  = 1'b0;
            skid_vld_d  = 1'b0;
            instr_vld_d = 1'b0;
        end else if (advance) begin
            if (skid_vld_q) begin
                instr_vld_d = 1'b1;
                instr_dat_d = skid_dat_q;
                instr_pc_d  = skid_pc_q;
                // Data landing this cycle takes the slot just vacated in the skid.
                skid_vld_d  = pend_vld_q;
                skid_dat_d  = bus.mem_rdata;
                skid_pc_d   = pend_pc_q;
            end else if (pend_vld_q) begin
                instr_vld_d = 1'b1;
                instr_dat_d = bus.mem_rdata;
                instr_pc_d  = pend_pc_q;
            end else begin
                instr_vld_d = 1'b0;
            end
        end else if (pend_vld_q) begin
            skid_vld_d = 1'b1;
            skid_dat_d = bus.mem_rdata;
            skid_pc_d  = pend_pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RUN;
            halted_q    <= 1'b0;
            pc_q        <= '0;
            pend_vld_q  <= 1'b0;
            pend_pc_q   <= '0;
            skid_vld_q  <= 1'b0;
            skid_dat_q  <= '0;
            skid_pc_q   <= '0;
            instr_vld_q <= 1'b0;
            instr_dat_q <= '0;
            instr_pc_q  <= '0;
        end else begin
            pc_q        <= pc_d;
            pend_vld_q  <= pend_vld_d;
            pend_pc_q   <= pend_pc_d;
            skid_vld_q  <= skid_vld_d;
            skid_dat_q  <= skid_dat_d;
            skid_pc_q   <= skid_pc_d;
            instr_vld_q <= instr_vld_d;
            instr_dat_q <= instr_dat_d;
            instr_pc_q  <= instr_pc_d;

            case (state_q)
                S_RUN: begin
                    if (bus.halt_req) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (drained) begin
                        state_q  <= S_HALTED;
                        halted_q <= 1'b1;
                    end
                end
                S_HALTED: begin
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q  <= S_RUN;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_addr    = pc_q;
    assign bus.mem_rd      = issue;
    assign bus.instr       = instr_dat_q;
    assign bus.instr_valid = instr_vld_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.halted      = halted_q;
endmodule

// File: tb/tb_overture_fetch.sv
// Bench for overture_fetch: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized stall/branch/halt/reset.
module tb_overture_fetch;
    localparam int AW = 8;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    overture_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    overture_fetch #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // ROM: ROM[i] = i, one cycle latency; junk on the bus when nothing was read.
    logic          rom_rd_q   = 1'b0;
    logic [AW-1:0] rom_addr_q = '0;
    logic [DW-1:0] junk_q     = '0;

    function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
        return DW'(a);
    endfunction

    always @(posedge clk) begin
        rom_rd_q   <= bus.mem_rd;
        rom_addr_q <= bus.mem_addr;
        junk_q     <= DW'($urandom);
    end
    assign bus.mem_rdata = rom_rd_q ? rom(rom_addr_q) : junk_q;

    int errors = 0;
    int checks = 0;

    // Reference model: fetched-but-unpresented addresses are simply a FIFO queue.
    bit            m_known = 0;
    int            m_mode  = 0;  // 0 run, 1 drain, 2 halted
    logic [AW-1:0] m_pc    = '0;
    bit            m_vld   = 0;
    logic [DW-1:0] m_instr = '0;
    logic [AW-1:0] m_ipc   = '0;
    bit            m_halted = 0;
    logic [AW-1:0] m_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic step(input bit s, input bit bt, input logic [AW-1:0] tg, input bit h, input bit r);
        bit            acc;
        bit            rd;
        bit            adv_ok;
        int            qs;
        logic [AW-1:0] a;
        @(negedge clk);
        bus.stall         = s;
        bus.branch_taken  = bt;
        bus.branch_target = tg;
        bus.halt_req      = h;
        rst               = r;
        #1;
        acc = bt && m_vld && !s;
        rd  = !r && (m_mode == 0) && !h && !acc && !(s && (m_q.size() > 0));
        if (m_known) begin
            check("mem_rd", bus.mem_rd, rd);
            check("mem_addr", bus.mem_addr, m_pc);
            check("instr_valid", bus.instr_valid, m_vld);
            check("halted", bus.halted, m_halted);
            if (m_vld) begin
                check("instr", bus.instr, m_instr);
                check("instr_pc", bus.instr_pc, m_ipc);
            end
        end
        if (r) begin
            m_known = 1; m_mode = 0; m_pc = '0; m_vld = 0;
            m_instr = '0; m_ipc = '0; m_halted = 0;
            m_q.delete();
        end else if (m_known) begin
            qs     = m_q.size();
            adv_ok = !m_vld || !s;
            if (acc) begin
                m_q.delete();
                m_vld = 0;
                m_pc  = tg;
            end else if (adv_ok) begin
                if (qs > 0) begin
                    a       = m_q.pop_front();
                    m_instr = rom(a);
                    m_ipc   = a;
                    m_vld   = 1;
                end else begin
                    m_vld = 0;
                end
            end
            if (rd) begin
                m_q.push_back(m_pc);
                m_pc = m_pc + 1'b1;
            end
            if (m_mode == 0 && h) begin
                m_mode = 1;
            end else if (m_mode == 1 && qs == 0 && adv_ok) begin
                m_mode   = 2;
                m_halted = 1;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0);
    endtask

    bit halt_hold;

    initial begin
        rst = 1'b1;
        bus.stall = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_target = '0;
        bus.halt_req = 1'b0;

        // Reset, streaming, stall with skid, ignored branch, wrap.
        step(0, 0, '0, 0, 1);
        step(0, 0, '0, 0, 1);
        check("rst_mem_rd", bus.mem_rd, 0);
        step(0, 0, '0, 0, 0);                       // cycle 0
        check("c0_valid", bus.instr_valid, 0);
        check("c0_instr", bus.instr, 0);
        check("c0_instr_pc", bus.instr_pc, 0);
        check("c0_halted", bus.halted, 0);
        check("c0_mem_rd", bus.mem_rd, 1);
        check("c0_mem_addr", bus.mem_addr, 0);
        for (int c = 1; c <= 6; c++) begin
            step(0, 0, '0, 0, 0);
            if (c == 2) begin
                check("c2_valid", bus.instr_valid, 1);
                check("c2_instr", bus.instr, 0);
            end
        end
        step(1, 0, '0, 0, 0);                       // cycle 7
        check("stall_c7", bus.instr, 5);
        step(1, 1, 8'h80, 0, 0);                    // branch under stall is ignored
        check("stall_c8", bus.instr, 5);
        step(1, 0, '0, 0, 0);
        check("stall_c9", bus.instr, 5);
        step(0, 0, '0, 0, 0);
        check("stall_c10", bus.instr, 5);
        step(0, 0, '0, 0, 0);
        check("after_stall_6", bus.instr, 6);
        step(0, 0, '0, 0, 0);
        check("after_stall_7", bus.instr, 7);
        for (int c = 13; c <= 261; c++) begin
            step(0, 0, '0, 0, 0);
            if (c == 260) check("wrap_255", bus.instr, 255);
        end
        check("wrap_0_valid", bus.instr_valid, 1);
        check("wrap_0_instr", bus.instr, 0);
        check("wrap_0_pc", bus.instr_pc, 0);

        // Taken branch: two bubbles then target.
        step(0, 0, '0, 0, 1);
        run(5);
        step(0, 1, 8'h40, 0, 0);                    // cycle 5
        check("br_src", bus.instr, 3);
        step(0, 0, '0, 0, 0);
        check("br_bubble1", bus.instr_valid, 0);
        step(0, 0, '0, 0, 0);
        check("br_bubble2", bus.instr_valid, 0);
        step(0, 0, '0, 0, 0);
        check("br_tgt_valid", bus.instr_valid, 1);
        check("br_tgt", bus.instr, 8'h40);
        check("br_tgt_pc", bus.instr_pc, 8'h40);
        step(0, 0, '0, 0, 0);
        check("br_tgt_next", bus.instr, 8'h41);

        // Halt with drain.
        step(0, 0, '0, 0, 1);
        run(12);
        step(0, 0, '0, 1, 0);                       // cycle 12
        check("halt_at_10", bus.instr, 10);
        step(0, 0, '0, 1, 0);
        check("drain_11", bus.instr, 11);
        check("drain_not_halted", bus.halted, 0);
        step(0, 0, '0, 1, 0);
        check("halted", bus.halted, 1);
        check("halted_valid", bus.instr_valid, 0);
        check("halted_mem_rd", bus.mem_rd, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, '0, 0, 0);
            check("halted_stays_rd", bus.mem_rd, 0);
        end

        // Reset while a read is outstanding.
        step(0, 0, '0, 0, 1);
        run(4);
        step(0, 0, '0, 0, 1);
        step(0, 0, '0, 0, 0);
        check("mid_rst_valid0", bus.instr_valid, 0);
        check("mid_rst_addr0", bus.mem_addr, 0);
        step(0, 0, '0, 0, 0);
        check("mid_rst_valid1", bus.instr_valid, 0);
        step(0, 0, '0, 0, 0);
        check("mid_rst_first", bus.instr, 0);
        check("mid_rst_first_vld", bus.instr_valid, 1);

        // Randomized traffic.
        for (int r = 0; r < 8; r++) begin
            step(0, 0, '0, 0, 1);
            halt_hold = 0;
            for (int i = 0; i < 400; i++) begin
                bit s, bt, rr;
                logic [AW-1:0] tg;
                s  = ($urandom_range(99) < 30);
                bt = ($urandom_range(99) < 12);
                tg = AW'($urandom);
                if ($urandom_range(199) < 2) halt_hold = 1;
                rr = ($urandom_range(999) < 5);
                step(s, bt, tg, halt_hold, rr);
                if (rr) halt_hold = 0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
